// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter for one shared registered data bit, with a per-grant burst limit.
// Grant follows request by 1 edge; a transfer lands on d_out 1 edge after the grant.
module dff_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         d_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    d_out,
  output logic                    d_valid,
  output logic [$clog2(NREQ)-1:0] d_src
);

  localparam int SW = $clog2(NREQ);
  localparam logic [3:0] MB4 = 4'(MAX_BURST);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic            d_out_q, d_out_d;
  logic            d_valid_q, d_valid_d;
  logic [SW-1:0]   d_src_q, d_src_d;

  logic            xfer;
  logic            release_gnt;
  logic [SW-1:0]   nxt_ptr;

  // First set request at or above start, wrapping; rotating makes the lowest
  // rotated position the winner.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [SW-1:0]   start);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SW:0]       sum;
    dbl     = {r, r};
    rot     = NREQ'(dbl >> start);
    rr_pick = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start} + (SW+1)'(k);
        if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
        rr_pick = sum[SW-1:0];
      end
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    d_out_d     = d_out_q;
    d_src_d     = d_src_q;
    d_valid_d   = 1'b0;
    xfer        = 1'b0;
    release_gnt = 1'b0;
    nxt_ptr     = ptr_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d     = rr_pick(req, ptr_q);
          gnt_d       = onehot(owner_d);
          burst_cnt_d = 4'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        xfer = req[owner_q];
        if (xfer) begin
          d_out_d     = d_in[owner_q];
          d_src_d     = owner_q;
          d_valid_d   = 1'b1;
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        release_gnt = !xfer || (burst_cnt_q + 4'd1 == MB4);
        if (release_gnt) begin
          // Hand over on the same edge so a waiting requester never sees an idle cycle.
          nxt_ptr     = (owner_q == SW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          ptr_d       = nxt_ptr;
          burst_cnt_d = 4'd0;
          if (|req) begin
            owner_d = rr_pick(req, nxt_ptr);
            gnt_d   = onehot(owner_d);
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= 4'd0;
      d_out_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_src_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      d_out_q     <= d_out_d;
      d_valid_q   <= d_valid_d;
      d_src_q     <= d_src_d;
    end
  end

  assign gnt     = gnt_q;
  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign d_src   = d_src_q;

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Scoreboarded bench: stimulus steps an abstract arbiter model and queues
// expected grants/transfers; a monitor pops and compares after every edge.
module tb_dff_rr_arbiter;

  localparam int N     = 4;
  localparam int MB    = 4;
  localparam int BOUND = (N - 1) * MB + N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] d_in = '0;
  logic [N-1:0] gnt;
  logic         d_out;
  logic         d_valid;
  logic [1:0]   d_src;

  always #5 clk = ~clk;

  dff_rr_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .d_in   (d_in),
    .gnt    (gnt),
    .d_out  (d_out),
    .d_valid(d_valid),
    .d_src  (d_src)
  );

  typedef struct {
    logic       d;
    logic [1:0] s;
  } xfer_t;

  int           total = 0;
  int           bad = 0;
  logic [N-1:0] gq[$];
  xfer_t        xq[$];

  // Abstract model: owner index (-1 = nobody), search start, transfers in this grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = r >> ((start + k) % N);
      if (t[0]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Present inputs for the coming edge and predict what that edge does.
  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] d);
    logic [N-1:0] t;
    bit           rel;
    xfer_t        x;
    req  = r;
    d_in = d;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = pick(r, m_ptr);
        m_cnt   = 0;
      end
    end else begin
      t = r >> m_owner;
      if (t[0]) begin
        t   = d >> m_owner;
        x.d = t[0];
        x.s = 2'(m_owner);
        xq.push_back(x);
        m_cnt++;
        rel = (m_cnt == MB);
      end else begin
        rel = 1'b1;
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(r, m_ptr);
        m_cnt   = 0;
      end
    end
    gq.push_back(m_owner < 0 ? '0 : (N'(1) << m_owner));
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d);
    @(negedge clk);
    apply(r, d);
  endtask

  task automatic do_reset(input logic [N-1:0] r, input logic [N-1:0] d);
    @(negedge clk);
    chk("gq_drained", gq.size(), 0);
    chk("xq_drained", xq.size(), 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_src", d_src, 0);
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    gq.delete();
    xq.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_gnt", gnt, 0);
    chk("rst_hold_valid", d_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    apply(r, d);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic [N-1:0] prev_gnt = '0;
  int           wt[N];

  initial begin
    xfer_t x;
    for (int i = 0; i < N; i++) wt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("onehot0", 32'($onehot0(gnt)), 1);
        if (gq.size() > 0) chk("gnt", gnt, gq.pop_front());
        if (d_valid) begin
          chk("src_was_granted", prev_gnt[d_src], 1);
          if (xq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer: got d_valid=1 want 0 at %0t", $time);
          end else begin
            x = xq.pop_front();
            chk("d_out", d_out, x.d);
            chk("d_src", d_src, x.s);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (req[i] && !gnt[i]) wt[i]++;
          else wt[i] = 0;
          if (wt[i] > BOUND) begin
            total++;
            bad++;
            $display("FAIL starve: req %0d waited %0d want <= %0d", i, wt[i], BOUND);
            wt[i] = 0;
          end
        end
        prev_gnt = gnt;
      end else begin
        prev_gnt = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
      end
    end
  end

  // Stimulus
  initial begin
    logic [4:0]   pat;
    logic [N-1:0] cur;

    // Reset mid-burst with d_out=1, then a fresh request after release.
    do_reset(4'b0001, 4'b0001);
    drive(4'b0001, 4'b0001);
    after_edge();
    chk("pre_rst_d_out", d_out, 1);
    do_reset(4'b0010, 4'b0000);
    after_edge();
    chk("post_rst_gnt", gnt, 4'b0010);

    // Single requester: burst limit then immediate re-grant.
    pat = 5'b01101;
    do_reset(4'b0001, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, {3'b000, pat[k]});
      after_edge();
      chk("solo_valid", d_valid, 1);
      chk("solo_d_out", d_out, pat[k]);
      chk("solo_src", d_src, 0);
      if (k == 3) chk("solo_regrant", gnt, 4'b0001);
    end

    // All requesting: fixed rotation of 4-transfer bursts.
    do_reset(4'b1111, 4'(($urandom)));
    after_edge();
    chk("rot_gnt0", gnt, 4'b0001);
    for (int k = 1; k < 20; k++) begin
      drive(4'b1111, 4'($urandom));
      after_edge();
      chk("rot_gnt", gnt, 32'(1) << ((k / 4) % 4));
      chk("rot_valid", d_valid, 1);
      chk("rot_src", d_src, ((k - 1) / 4) % 4);
    end

    // Owner drops request: hand-over with no idle cycle.
    do_reset(4'b0110, 4'b0110);
    drive(4'b0110, 4'b0110);
    drive(4'b0110, 4'b0000);
    drive(4'b0100, 4'b0100);
    after_edge();
    chk("drop_gnt", gnt, 4'b0100);
    chk("drop_valid", d_valid, 0);
    drive(4'b0100, 4'b0100);
    after_edge();
    chk("drop_next_valid", d_valid, 1);
    chk("drop_next_src", d_src, 2);

    // Return to idle from requester 3, pointer wraps to 0.
    do_reset(4'b1000, 4'b1000);
    drive(4'b1000, 4'b1000);
    after_edge();
    chk("wrap_xfer_src", d_src, 3);
    drive(4'b0000, 4'b0000);
    after_edge();
    chk("wrap_idle_gnt", gnt, 4'b0000);
    drive(4'b1001, 4'b0000);
    after_edge();
    chk("wrap_gnt", gnt, 4'b0001);

    // Random traffic with slowly changing requests, one reset mid-run.
    cur = '0;
    do_reset(cur, '0);
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) cur[b] = ~cur[b];
      if (i == 5000) do_reset(cur, 4'($urandom));
      else drive(cur, 4'($urandom));
    end
    drive(4'b0000, 4'b0000);
    @(negedge clk);
    chk("final_gq", gq.size(), 0);
    chk("final_xq", xq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_rr_arbiter.md
DFF_RR_ARBITER -- requirements
Module: dff_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing the registered bit stage; legal range 2..8.
REQ-002 The block SHALL have parameter MAX_BURST, default 4: maximum consecutive transfers per grant; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 The block SHALL have port req  input  NREQ  per-requester request; bit i high = requester i has a bit to deliver.
REQ-006 The block SHALL have port d_in  input  NREQ  per-requester data bit; d_in[i] is sampled only on a transfer for requester i.
REQ-007 The block SHALL have port gnt  output  NREQ  registered one-hot grant, or all-zero when idle.
REQ-008 The block SHALL have port d_out  output  1  shared registered data bit (the flop stage being arbitrated).
REQ-009 The block SHALL have port d_valid  output  1  high for exactly one cycle per transfer, aligned with d_out.
REQ-010 The block SHALL have port d_src  output  clog2(NREQ)  index of the requester whose bit is on d_out.

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt == 0) and BUSY (gnt one-hot, owner = index of set bit).
REQ-012 At every rising edge in IDLE with req != 0, the block SHALL set gnt to the round-robin winner, enter BUSY and clear burst_cnt; it SHALL not transfer on that edge.
REQ-013 The round-robin winner SHALL be the first set req bit searched upward from index ptr, wrapping NREQ-1 -> 0.
REQ-014 At a rising edge in BUSY with req[owner] high (a transfer), the block SHALL load d_out <= d_in[owner], d_src <= owner, d_valid <= 1 and increment burst_cnt.
REQ-015 At every rising edge without a transfer, d_valid SHALL load 0; d_out and d_src SHALL hold their values.
REQ-016 In BUSY, the grant SHALL be released at an edge when req[owner] is low (no transfer) or the transfer brings burst_cnt to MAX_BURST (final transfer still occurs).
REQ-017 On release, ptr SHALL load (owner+1) mod NREQ, and on the same edge gnt SHALL load the winner computed from the current req with the new ptr (so no idle cycle), or 0 with a return to IDLE if req == 0.
REQ-018 The released owner SHALL be eligible on the release edge; when it is the only requester it SHALL be re-granted with burst_cnt cleared.
REQ-019 burst_cnt SHALL be 4 bits, SHALL clear on every new grant and SHALL never exceed MAX_BURST.
REQ-020 Total latency SHALL be req rise -> gnt high 1 edge; gnt high with req held -> d_valid high 1 edge later; in steady state there is 1 transfer per cycle.
REQ-021 gnt SHALL never have more than one bit set, and gnt SHALL only be set for a requester whose req was high at the granting edge.
REQ-022 Changes of req[j] for j != owner SHALL have no effect during BUSY until the next release.

Reset
REQ-023 While rst is low, the block SHALL immediately force gnt=0, d_out=0, d_valid=0, d_src=0, ptr=0, burst_cnt=0 and state IDLE, independent of clk.
REQ-024 Reset asserted during BUSY SHALL abort the burst with no further transfers.
REQ-025 After rst goes high, the first grant SHALL occur no earlier than the first rising edge that samples rst high.

Verification (NREQ=4, MAX_BURST=4)
REQ-026 Drive rst low mid-BUSY with d_out=1 -> gnt=0000, d_out=0, d_valid=0 before the next edge; after release, req=0010 -> gnt=0010 at the first edge.
REQ-027 Hold req=0001 with d_in[0] toggling 1,0,1,1,0 -> d_valid high on 4 consecutive cycles with d_out = 1,0,1,1 and d_src=0; release, re-grant 0001 with no gap, then the 5th transfer d_out=0.
REQ-028 Hold req=1111 from reset -> the grant order is 0001,0010,0100,1000,0001, each holding for 4 transfers, with d_src following 0,1,2,3,0.
REQ-029 Set req=0110, then drop req[1] after 2 transfers -> on the no-transfer edge gnt goes 0010 -> 0100 with no IDLE cycle, and d_valid is low for that one cycle.
REQ-030 Set req=0000 after a single-transfer grant to requester 3 -> gnt=0000, state IDLE; then req=1001 -> gnt=0001 (ptr wrapped to 0).
REQ-031 Run random req/d_in for 10k cycles -> the assertions hold: gnt one-hot-or-zero; d_valid implies d_src was granted the prior cycle; no requester is starved beyond (NREQ-1)*MAX_BURST+NREQ cycles.
